// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   - RV32I funct3 width/sign codes
//   - FSM state encoding
//   - latched request record
//   - legality check, store write-mask and lane-replication helpers
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, LOAD, RESP} lsu_state_e;

    // Request fields that must survive past the accept edge.
    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] off;
        logic       err;
        logic       io;
    } lsu_req_t;

    // Illegal funct3 for the direction, or address not aligned to the access size.
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic bad_f3;
        logic misal;
        if (we) bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
        else    bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misal = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return bad_f3 | misal;
    endfunction

    function automatic logic [3:0] wmask_of(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store value across every lane it could land in.
    function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data alignment and extension.
//   word    in  32  raw memory word
//   off     in  2   byte offset addr[1:0]
//   funct3  in  3   load width/sign code
//   result  out 32  selected byte/half/word, sign- or zero-extended
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        // Halfwords are aligned, so only addr[1] picks the half.
        half_sel = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit between the execute stage and a single-port
// word memory with 1-cycle registered read and byte write mask.
// One transaction in flight; all outputs registered.
//   clk, reset                 clock, async active-high reset
//   req_valid/ready/we/funct3/addr/wdata   request from the core
//   rsp_valid/rdata/err        one-cycle completion pulse and result
//   mem_addr/rstrb/wdata/wmask/rdata       word memory port
// Optional macro LSU_IO_EN adds io_addr/io_wdata/io_wstrb/io_rstrb/io_rdata;
// accesses with addr[IO_BIT]=1 go there instead and must be word-sized.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IO_BIT = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rstrb,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata
`ifdef LSU_IO_EN
    ,
    output logic [ADDR_W-1:0] io_addr,
    output logic [31:0]       io_wdata,
    output logic              io_wstrb,
    output logic              io_rstrb,
    input  logic [31:0]       io_rdata
`endif
);

    lsu_state_e  state;
    lsu_req_t    rq;
    logic        acc_bad;
    logic        acc_io;
    logic [31:0] load_word;
    logic [31:0] load_res;

`ifdef LSU_IO_EN
    assign acc_io    = req_addr[IO_BIT];
    assign acc_bad   = req_bad(req_we, req_funct3, req_addr[1:0]) | (acc_io && (req_funct3 != F3_W));
    assign load_word = rq.io ? io_rdata : mem_rdata;
`else
    assign acc_io    = 1'b0;
    assign acc_bad   = req_bad(req_we, req_funct3, req_addr[1:0]);
    assign load_word = mem_rdata;
`endif

    lsu_load_align u_align (
        .word   (load_word),
        .off    (rq.off),
        .funct3 (rq.funct3),
        .result (load_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rq        <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_addr  <= '0;
            mem_rstrb <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
`ifdef LSU_IO_EN
            io_addr   <= '0;
            io_wdata  <= '0;
            io_wstrb  <= 1'b0;
            io_rstrb  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    rq        <= '{we: req_we, funct3: req_funct3, off: req_addr[1:0],
                                   err: acc_bad, io: acc_io};
                    mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata <= wdata_of(req_funct3, req_wdata);
                    rsp_rdata <= '0;
                    req_ready <= 1'b0;
                    state     <= ACCESS;
`ifdef LSU_IO_EN
                    io_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
                    io_wdata  <= req_wdata;
`endif
                    // Errors still spend the ACCESS slot, strobes held low, so
                    // they complete with the same latency as a store.
                    if (!acc_bad) begin
`ifdef LSU_IO_EN
                        if (acc_io) begin
                            io_wstrb <= req_we;
                            io_rstrb <= !req_we;
                        end else
`endif
                        if (req_we) mem_wmask <= wmask_of(req_funct3, req_addr[1:0]);
                        else        mem_rstrb <= 1'b1;
                    end
                end
                ACCESS: begin
                    mem_wmask <= '0;
                    mem_rstrb <= 1'b0;
`ifdef LSU_IO_EN
                    io_wstrb  <= 1'b0;
                    io_rstrb  <= 1'b0;
`endif
                    if (rq.we || rq.err) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= rq.err;
                    end else begin
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    rsp_rdata <= load_res;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
